// File: rtl/fu_issue_arbiter.sv
// Two-level round-robin issue arbiter: picks one class per cycle, then one unit inside it.
// All grant outputs are registered; last cycle's grant masks its class and unit.
module fu_issue_arbiter #(
    parameter int NUM_CLASSES     = 4,
    parameter int UNITS_PER_CLASS = 4,
    parameter int WFID_W          = 6,
    parameter int CLS_W           = $clog2(NUM_CLASSES),
    parameter int UNIT_W          = (UNITS_PER_CLASS > 1) ? $clog2(UNITS_PER_CLASS) : 1
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [NUM_CLASSES-1:0]                 i_class_wf_valid,
    input  logic [NUM_CLASSES*WFID_W-1:0]          i_class_wf_id,
    input  logic [NUM_CLASSES*UNITS_PER_CLASS-1:0] i_unit_ready,
    input  logic [NUM_CLASSES-1:0]                 i_class_enable,
    input  logic                                   i_stall,
    output logic                                   o_issued_valid,
    output logic [WFID_W-1:0]                      o_issued_wfid,
    output logic [CLS_W-1:0]                       o_issued_class,
    output logic [NUM_CLASSES*UNITS_PER_CLASS-1:0] o_unit_select,
    output logic [NUM_CLASSES-1:0]                 o_class_ack
);

    localparam int NU = NUM_CLASSES * UNITS_PER_CLASS;

    logic                       r_issued_valid;
    logic [WFID_W-1:0]          r_issued_wfid;
    logic [CLS_W-1:0]           r_issued_class;
    logic [NU-1:0]              r_unit_select;
    logic [NUM_CLASSES-1:0]     r_class_ack;
    logic [CLS_W-1:0]           r_last_class;
    logic [UNIT_W-1:0]          r_last_unit [NUM_CLASSES];

    logic [NU-1:0]              w_ready_eff;
    logic [NUM_CLASSES-1:0]     w_class_elig;
    logic                       w_found;
    logic                       w_unit_found;
    logic                       w_grant;
    logic [CLS_W-1:0]           w_win_class;
    logic [UNIT_W-1:0]          w_win_unit;
    logic [UNITS_PER_CLASS-1:0] w_win_ready;
    logic [NU-1:0]              w_sel_onehot;
    logic [NUM_CLASSES-1:0]     w_ack_onehot;
    logic [WFID_W-1:0]          w_win_wfid;

    function automatic int wrap_add(input int base, input int step, input int modulus);
        return (base + step) % modulus;
    endfunction

    // The unit granted last cycle is not ready yet from the arbiter's point of view
    assign w_ready_eff = i_unit_ready & ~r_unit_select;
    assign w_grant     = w_found & ~i_stall;

    // Per-class eligibility, excluding the class acknowledged last cycle
    always_comb begin
        w_class_elig = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            w_class_elig[c] = i_class_wf_valid[c] & i_class_enable[c] & ~r_class_ack[c]
                              & (|w_ready_eff[c*UNITS_PER_CLASS +: UNITS_PER_CLASS]);
        end
    end

    // Round-robin class pick followed by round-robin unit pick in the winner
    always_comb begin
        w_found      = 1'b0;
        w_win_class  = '0;
        w_unit_found = 1'b0;
        w_win_unit   = '0;
        for (int k = 1; k <= NUM_CLASSES; k++) begin
            if (!w_found && w_class_elig[wrap_add(int'(r_last_class), k, NUM_CLASSES)]) begin
                w_found     = 1'b1;
                w_win_class = CLS_W'(wrap_add(int'(r_last_class), k, NUM_CLASSES));
            end else begin
                w_found = w_found;
            end
        end
        w_win_ready = w_ready_eff[int'(w_win_class)*UNITS_PER_CLASS +: UNITS_PER_CLASS];
        for (int k = 1; k <= UNITS_PER_CLASS; k++) begin
            if (!w_unit_found &&
                w_win_ready[wrap_add(int'(r_last_unit[w_win_class]), k, UNITS_PER_CLASS)]) begin
                w_unit_found = 1'b1;
                w_win_unit   = UNIT_W'(wrap_add(int'(r_last_unit[w_win_class]), k, UNITS_PER_CLASS));
            end else begin
                w_unit_found = w_unit_found;
            end
        end
        w_sel_onehot = '0;
        w_sel_onehot[int'(w_win_class)*UNITS_PER_CLASS + int'(w_win_unit)] = 1'b1;
        w_ack_onehot = '0;
        w_ack_onehot[w_win_class] = 1'b1;
        w_win_wfid = i_class_wf_id[int'(w_win_class)*WFID_W +: WFID_W];
    end

    // Grant outputs and round-robin pointers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_issued_valid <= 1'b0;
            r_issued_wfid  <= '0;
            r_issued_class <= '0;
            r_unit_select  <= '0;
            r_class_ack    <= '0;
            r_last_class   <= CLS_W'(NUM_CLASSES - 1);
            for (int c = 0; c < NUM_CLASSES; c++) begin
                r_last_unit[c] <= UNIT_W'(UNITS_PER_CLASS - 1);
            end
        end else if (w_grant) begin
            r_issued_valid           <= 1'b1;
            r_issued_wfid            <= w_win_wfid;
            r_issued_class           <= w_win_class;
            r_unit_select            <= w_sel_onehot;
            r_class_ack              <= w_ack_onehot;
            r_last_class             <= w_win_class;
            r_last_unit[w_win_class] <= w_win_unit;
        end else begin
            r_issued_valid <= 1'b0;
            r_issued_wfid  <= '0;
            r_issued_class <= '0;
            r_unit_select  <= '0;
            r_class_ack    <= '0;
        end
    end

    assign o_issued_valid = r_issued_valid;
    assign o_issued_wfid  = r_issued_wfid;
    assign o_issued_class = r_issued_class;
    assign o_unit_select  = r_unit_select;
    assign o_class_ack    = r_class_ack;

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Bench for fu_issue_arbiter: directed vector table, hand sequences, random run
// against a distance-based reference model, and a 6-class single-unit instance.
module tb_fu_issue_arbiter;

    localparam int NC = 4;
    localparam int NU = 4;
    localparam int WW = 6;
    localparam int BNC = 6;
    localparam int BWW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, stall;
    logic [NC-1:0]   valid, en;
    logic [NC*WW-1:0] ids;
    logic [NC*NU-1:0] ready;
    logic            o_v;
    logic [WW-1:0]   o_id;
    logic [1:0]      o_cls;
    logic [NC*NU-1:0] o_sel;
    logic [NC-1:0]   o_ack;

    logic             b_rst, b_stall;
    logic [BNC-1:0]   b_valid, b_en, b_ready;
    logic [BNC*BWW-1:0] b_ids;
    logic             b_o_v;
    logic [BWW-1:0]   b_o_id;
    logic [2:0]       b_o_cls;
    logic [BNC-1:0]   b_o_sel, b_o_ack;

    fu_issue_arbiter #(.NUM_CLASSES(NC), .UNITS_PER_CLASS(NU), .WFID_W(WW)) dut (
        .i_clk(clk), .i_rst(rst), .i_class_wf_valid(valid), .i_class_wf_id(ids),
        .i_unit_ready(ready), .i_class_enable(en), .i_stall(stall),
        .o_issued_valid(o_v), .o_issued_wfid(o_id), .o_issued_class(o_cls),
        .o_unit_select(o_sel), .o_class_ack(o_ack));

    fu_issue_arbiter #(.NUM_CLASSES(BNC), .UNITS_PER_CLASS(1), .WFID_W(BWW)) dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_class_wf_valid(b_valid), .i_class_wf_id(b_ids),
        .i_unit_ready(b_ready), .i_class_enable(b_en), .i_stall(b_stall),
        .o_issued_valid(b_o_v), .o_issued_wfid(b_o_id), .o_issued_class(b_o_cls),
        .o_unit_select(b_o_sel), .o_class_ack(b_o_ack));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [3:0]  valid;
        logic [3:0]  en;
        logic        e_v;
        logic [1:0]  e_cls;
        logic [5:0]  e_id;
        logic [15:0] e_sel;
        logic [3:0]  e_ack;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic r, input logic s, input logic [3:0] v, input logic [3:0] e,
                                input logic ev, input logic [1:0] ec, input logic [5:0] ei,
                                input logic [15:0] es, input logic [3:0] ea);
        vec_t t;
        t.rst = r; t.stall = s; t.valid = v; t.en = e;
        t.e_v = ev; t.e_cls = ec; t.e_id = ei; t.e_sel = es; t.e_ack = ea;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [1:0] ec,
                             input logic [5:0] ei, input logic [15:0] es, input logic [3:0] ea);
        check($sformatf("%s.valid", tag), {63'd0, o_v}, {63'd0, ev});
        check($sformatf("%s.class", tag), {62'd0, o_cls}, {62'd0, ec});
        check($sformatf("%s.wfid", tag), {58'd0, o_id}, {58'd0, ei});
        check($sformatf("%s.unit_sel", tag), {48'd0, o_sel}, {48'd0, es});
        check($sformatf("%s.ack", tag), {60'd0, o_ack}, {60'd0, ea});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; valid = 4'h0; stall = 1'b0; en = 4'hF; ready = 16'hFFFF;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Reference model: pick by smallest rotational distance from the last winner.
    int m_last_class;
    int m_last_unit [NC];
    int m_prev_class;
    int m_prev_bit;
    logic        x_v;
    logic [1:0]  x_cls;
    logic [5:0]  x_id;
    logic [15:0] x_sel;
    logic [3:0]  x_ack;

    task automatic model_reset;
        m_last_class = NC - 1;
        for (int c = 0; c < NC; c++) m_last_unit[c] = NU - 1;
        m_prev_class = -1;
        m_prev_bit = -1;
    endtask

    task automatic model_step;
        int best_c, best_d, best_u, du;
        x_v = 1'b0; x_cls = 2'd0; x_id = 6'd0; x_sel = 16'd0; x_ack = 4'd0;
        if (rst) begin
            model_reset();
            return;
        end
        best_c = -1; best_d = NC + 1;
        for (int c = 0; c < NC; c++) begin
            bit has_unit = 1'b0;
            for (int u = 0; u < NU; u++)
                if (ready[c*NU+u] && (c*NU+u) != m_prev_bit) has_unit = 1'b1;
            if (valid[c] && en[c] && c != m_prev_class && has_unit &&
                ((c - m_last_class - 1 + 2*NC) % NC) < best_d) begin
                best_d = (c - m_last_class - 1 + 2*NC) % NC;
                best_c = c;
            end
        end
        if (stall || best_c < 0) begin
            m_prev_class = -1;
            m_prev_bit = -1;
            return;
        end
        best_u = -1; du = NU + 1;
        for (int u = 0; u < NU; u++)
            if (ready[best_c*NU+u] && (best_c*NU+u) != m_prev_bit &&
                ((u - m_last_unit[best_c] - 1 + 2*NU) % NU) < du) begin
                du = (u - m_last_unit[best_c] - 1 + 2*NU) % NU;
                best_u = u;
            end
        x_v = 1'b1;
        x_cls = 2'(best_c);
        x_id = ids[best_c*WW +: WW];
        x_sel = 16'd1 << (best_c*NU + best_u);
        x_ack = 4'd1 << best_c;
        m_last_class = best_c;
        m_last_unit[best_c] = best_u;
        m_prev_class = best_c;
        m_prev_bit = best_c*NU + best_u;
    endtask

    initial begin
        int useq [3];
        // rst, stall, valid, en | valid, class, wfid, unit_select, ack
        tbl[0]  = mk(1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 2'd0, 6'd0, 16'h0000, 4'h0);
        tbl[1]  = mk(1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 2'd0, 6'd0, 16'h0000, 4'h0);
        tbl[2]  = mk(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 2'd0, 6'd0, 16'h0000, 4'h0);
        tbl[3]  = mk(1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 2'd0, 6'd1, 16'h0001, 4'h1);
        tbl[4]  = mk(1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 2'd1, 6'd2, 16'h0010, 4'h2);
        tbl[5]  = mk(1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 2'd2, 6'd3, 16'h0100, 4'h4);
        tbl[6]  = mk(1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 2'd3, 6'd4, 16'h1000, 4'h8);
        tbl[7]  = mk(1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 2'd0, 6'd1, 16'h0002, 4'h1);
        tbl[8]  = mk(1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 2'd1, 6'd2, 16'h0020, 4'h2);
        tbl[9]  = mk(1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 2'd0, 6'd0, 16'h0000, 4'h0);
        tbl[10] = mk(1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 2'd0, 6'd0, 16'h0000, 4'h0);
        tbl[11] = mk(1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 2'd0, 6'd0, 16'h0000, 4'h0);
        tbl[12] = mk(1'b0, 1'b0, 4'hF, 4'hB, 1'b1, 2'd3, 6'd4, 16'h2000, 4'h8);
        tbl[13] = mk(1'b0, 1'b0, 4'hF, 4'hB, 1'b1, 2'd0, 6'd1, 16'h0004, 4'h1);
        tbl[14] = mk(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 2'd0, 6'd0, 16'h0000, 4'h0);

        rst = 1'b1; stall = 1'b0; valid = 4'h0; en = 4'hF; ready = 16'hFFFF;
        ids = {6'd4, 6'd3, 6'd2, 6'd1};
        b_rst = 1'b1; b_stall = 1'b0; b_valid = 6'h3F; b_en = 6'h3F; b_ready = 6'h3F;
        for (int c = 0; c < BNC; c++) b_ids[c*BWW +: BWW] = 8'hC0 | 8'(c);

        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst; stall = tbl[i].stall; valid = tbl[i].valid; en = tbl[i].en;
            tick();
            check_out($sformatf("tbl%0d", i), tbl[i].e_v, tbl[i].e_cls, tbl[i].e_id,
                      tbl[i].e_sel, tbl[i].e_ack);
        end

        // Unit rotation with a lone class: grants every second cycle
        do_reset();
        valid = 4'h2;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i % 2 == 0)
                check_out($sformatf("urot%0d", i), 1'b1, 2'd1, 6'd2,
                          16'h0010 << ((i/2) % 4), 4'h2);
            else
                check_out($sformatf("urot%0d", i), 1'b0, 2'd0, 6'd0, 16'h0000, 4'h0);
        end

        // Sparse ready slice 0101 on class 1
        do_reset();
        useq[0] = 0; useq[1] = 2; useq[2] = 0;
        valid = 4'h2; ready = 16'h0050;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i % 2 == 0)
                check_out($sformatf("umask%0d", i), 1'b1, 2'd1, 6'd2,
                          16'h0010 << useq[i/2], 4'h2);
            else
                check_out($sformatf("umask%0d", i), 1'b0, 2'd0, 6'd0, 16'h0000, 4'h0);
        end

        // Reset arriving on the cycle class 2 unit 1 would be granted
        do_reset();
        valid = 4'h4;
        tick();
        check_out("mrst_g0", 1'b1, 2'd2, 6'd3, 16'h0100, 4'h4);
        tick();
        check_out("mrst_gap", 1'b0, 2'd0, 6'd0, 16'h0000, 4'h0);
        rst = 1'b1;
        tick();
        check_out("mrst_drop", 1'b0, 2'd0, 6'd0, 16'h0000, 4'h0);
        rst = 1'b0; valid = 4'hF;
        tick();
        check_out("mrst_after", 1'b1, 2'd0, 6'd1, 16'h0001, 4'h1);

        // Random stimulus against the reference model
        for (int i = 0; i < 400; i++) begin
            rst   = (i == 0) || ($urandom_range(0, 39) == 0);
            stall = ($urandom_range(0, 4) == 0);
            valid = 4'($urandom);
            en    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            ready = 16'($urandom) | 16'($urandom);
            ids   = 24'($urandom);
            model_step();
            tick();
            check_out($sformatf("rnd%0d", i), x_v, x_cls, x_id, x_sel, x_ack);
        end

        // Six classes, one unit each, 8-bit ids
        rst = 1'b1; valid = 4'h0;
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("par%0d.valid", k), {63'd0, b_o_v}, 64'd1);
            check($sformatf("par%0d.class", k), {61'd0, b_o_cls}, 64'(k % BNC));
            check($sformatf("par%0d.wfid", k), {56'd0, b_o_id}, 64'(8'hC0 | 8'(k % BNC)));
            check($sformatf("par%0d.unit_sel", k), {58'd0, b_o_sel}, 64'd1 << (k % BNC));
            check($sformatf("par%0d.ack", k), {58'd0, b_o_ack}, 64'd1 << (k % BNC));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
